// File: rtl/mbus_int_generator.sv
// MBus interrupt generator. This is the transmit side of the CLK-high / DATA-toggle
// interrupt. On a request it holds the bus clock high and toggles DATA in rise/fall
// pairs, then restores the bus clock level that was captured when the request was accepted.
// All bus outputs are registered, and CLK_OUT and DATA_OUT never change on the same edge.
module mbus_int_generator #(
  parameter int HALF_PERIOD = 4,  // system cycles per bus half-phase, >= 1
  parameter int NUM_PAIRS   = 3,  // DATA rise/fall pairs sent while CLK is high, >= 3
  parameter int CNT_W       = 8   // half-period counter width, 2**CNT_W > HALF_PERIOD
) (
  input  logic CLK,
  input  logic negp_reset,
  input  logic REQ,
  input  logic CLK_RESUME,
  output logic BUSY,
  output logic DONE,
  output logic CLK_OUT,
  output logic DATA_OUT
);

  // The edge counter indexes DATA levels inside TOG: 0 .. 2*NUM_PAIRS-1.
  localparam int                ECNT_W   = $clog2(2 * NUM_PAIRS + 1);
  localparam logic [CNT_W-1:0]  HLOAD    = CNT_W'(HALF_PERIOD - 1);
  localparam logic [ECNT_W-1:0] LAST_LVL = ECNT_W'(2 * NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_SETUP,
    S_TOG,
    S_RESTORE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [ECNT_W-1:0] ecnt_q, ecnt_d;
  logic              clk_resume_q, clk_resume_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clk_out_q, clk_out_d;
  logic              data_out_q, data_out_d;
  logic              step;

  // A state lasts one full half-period. It advances on the cycle the counter has run down to zero.
  assign step = (hcnt_q == '0);

  // Next-state and next-output logic. Each output is set on the edge that enters its
  // new state, so the bus pins come straight from flops.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    ecnt_d       = ecnt_q;
    clk_resume_d = clk_resume_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    clk_out_d    = clk_out_q;
    data_out_d   = data_out_q;

    case (state_q)
      S_IDLE: begin
        // The restore level was already placed on CLK_OUT when the sequence ended.
        // Entering PREP only drops DATA, so CLK keeps its current level for now.
        if (REQ) begin
          state_d      = S_PREP;
          hcnt_d       = HLOAD;
          clk_resume_d = CLK_RESUME;
          busy_d       = 1'b1;
          data_out_d   = 1'b0;
        end
      end

      S_PREP: begin
        // DATA has been low for a half-period. Raise CLK now, with DATA still stable.
        if (step) begin
          state_d   = S_SETUP;
          hcnt_d    = HLOAD;
          clk_out_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q - CNT_W'(1);
        end
      end

      S_SETUP: begin
        // CLK has been high for a half-period. The first DATA rise starts the toggling.
        if (step) begin
          state_d    = S_TOG;
          hcnt_d     = HLOAD;
          ecnt_d     = '0;
          data_out_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q - CNT_W'(1);
        end
      end

      S_TOG: begin
        // Each DATA level lasts a half-period. The last level is low, so leaving TOG
        // only has to move CLK.
        if (step) begin
          hcnt_d = HLOAD;
          if (ecnt_q == LAST_LVL) begin
            state_d   = S_RESTORE;
            ecnt_d    = '0;
            clk_out_d = clk_resume_q;
          end else begin
            ecnt_d     = ecnt_q + ECNT_W'(1);
            data_out_d = ~data_out_q;
          end
        end else begin
          hcnt_d = hcnt_q - CNT_W'(1);
        end
      end

      S_RESTORE: begin
        // CLK has settled at its restore level. Release DATA high and flag completion.
        if (step) begin
          state_d    = S_IDLE;
          hcnt_d     = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          data_out_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        hcnt_d     = '0;
        ecnt_d     = '0;
        busy_d     = 1'b0;
        clk_out_d  = clk_resume_q;
        data_out_d = 1'b1;
      end
    endcase
  end

  // State, counters and registered bus outputs. Reset forces the idle bus levels
  // immediately, and normal operation resumes on the first clock edge after release.
  always_ff @(posedge CLK or posedge negp_reset) begin
    if (negp_reset) begin
      state_q      <= S_IDLE;
      hcnt_q       <= '0;
      ecnt_q       <= '0;
      clk_resume_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      clk_out_q    <= 1'b1;
      data_out_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      ecnt_q       <= ecnt_d;
      clk_resume_q <= clk_resume_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      clk_out_q    <= clk_out_d;
      data_out_q   <= data_out_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign CLK_OUT  = clk_out_q;
  assign DATA_OUT = data_out_q;

endmodule
